// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: picks exception / MRET / interrupt, drains the
// pipeline, issues one CSR commit strobe, then one fetch redirect.
//
// state    | meaning
// IDLE     | waiting for a request; requests are sampled only here
// FLUSH    | flush_req held high until the pipeline acks the drain
// COMMIT   | one-cycle trap_take / mret_take with CSR write data
// REDIRECT | one-cycle redirect_valid to the trap vector or mepc
module trap_ctrl #(
    parameter logic       VECTORED_EN = 1'b1,
    parameter logic [1:0] MPP_VALUE   = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_valid,
    input  logic [3:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_tval,
    input  logic        mret_valid,
    input  logic        boundary_valid,
    input  logic [31:0] boundary_pc,
    input  logic        irq_sw,
    input  logic        irq_timer,
    input  logic        irq_ext,
    input  logic        i_mstatus_mie,
    input  logic        i_mstatus_mpie,
    input  logic        i_mie_msie,
    input  logic        i_mie_mtie,
    input  logic        i_mie_meie,
    input  logic [29:0] i_mtvec_base,
    input  logic [1:0]  i_mtvec_mode,
    input  logic [31:0] i_mepc_value,
    output logic        flush_req,
    input  logic        flush_ack,
    output logic        trap_take,
    output logic        mret_take,
    output logic        o_mcause_interrupt,
    output logic [30:0] o_mcause_exception_code,
    output logic [31:0] o_mepc_value,
    output logic [31:0] o_mtval_value,
    output logic        o_mstatus_mie,
    output logic        o_mstatus_mpie,
    output logic [1:0]  o_mstatus_mpp,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        COMMIT   = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    state_t      state;
    logic        lat_mret;
    logic        lat_int;
    logic [3:0]  lat_code;
    logic [31:0] lat_epc;
    logic [31:0] lat_tval;

    logic        mei_en;
    logic        msi_en;
    logic        mti_en;
    logic        irq_take;
    logic [3:0]  irq_code;
    logic [31:0] trap_base;
    logic [31:0] vec_offset;
    logic [31:0] target;

    assign mei_en   = irq_ext   & i_mie_meie;
    assign msi_en   = irq_sw    & i_mie_msie;
    assign mti_en   = irq_timer & i_mie_mtie;
    assign irq_take = boundary_valid & i_mstatus_mie & (mei_en | msi_en | mti_en);

    // Fixed interrupt priority: external, then software, then timer.
    always_comb begin
        irq_code = 4'd0;
        if (mei_en) begin
            irq_code = 4'd11;
        end else if (msi_en) begin
            irq_code = 4'd3;
        end else if (mti_en) begin
            irq_code = 4'd7;
        end
    end

    assign trap_base  = {i_mtvec_base, 2'b00};
    assign vec_offset = {26'd0, lat_code, 2'b00};

    // Target uses the CSR inputs as they stand before the commit lands.
    always_comb begin
        target = trap_base;
        if (lat_mret) begin
            target = i_mepc_value & 32'hFFFF_FFFC;
        end else if (VECTORED_EN && (i_mtvec_mode == 2'b01) && lat_int) begin
            target = trap_base + vec_offset;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                   <= IDLE;
            lat_mret                <= 1'b0;
            lat_int                 <= 1'b0;
            lat_code                <= 4'd0;
            lat_epc                 <= 32'd0;
            lat_tval                <= 32'd0;
            flush_req               <= 1'b0;
            trap_take               <= 1'b0;
            mret_take               <= 1'b0;
            o_mcause_interrupt      <= 1'b0;
            o_mcause_exception_code <= 31'd0;
            o_mepc_value            <= 32'd0;
            o_mtval_value           <= 32'd0;
            o_mstatus_mie           <= 1'b0;
            o_mstatus_mpie          <= 1'b0;
            o_mstatus_mpp           <= 2'b00;
            redirect_valid          <= 1'b0;
            redirect_pc             <= 32'd0;
        end else begin
            // Strobes and CSR data are only non-zero during their single cycle.
            trap_take               <= 1'b0;
            mret_take               <= 1'b0;
            o_mcause_interrupt      <= 1'b0;
            o_mcause_exception_code <= 31'd0;
            o_mepc_value            <= 32'd0;
            o_mtval_value           <= 32'd0;
            o_mstatus_mie           <= 1'b0;
            o_mstatus_mpie          <= 1'b0;
            o_mstatus_mpp           <= 2'b00;
            redirect_valid          <= 1'b0;
            redirect_pc             <= 32'd0;

            case (state)
                IDLE: begin
                    if (exc_valid) begin
                        lat_mret  <= 1'b0;
                        lat_int   <= 1'b0;
                        lat_code  <= exc_code;
                        lat_epc   <= exc_pc;
                        lat_tval  <= exc_tval;
                        state     <= FLUSH;
                        flush_req <= 1'b1;
                    end else if (mret_valid) begin
                        lat_mret  <= 1'b1;
                        lat_int   <= 1'b0;
                        lat_code  <= 4'd0;
                        lat_epc   <= 32'd0;
                        lat_tval  <= 32'd0;
                        state     <= FLUSH;
                        flush_req <= 1'b1;
                    end else if (irq_take) begin
                        lat_mret  <= 1'b0;
                        lat_int   <= 1'b1;
                        lat_code  <= irq_code;
                        lat_epc   <= boundary_pc;
                        lat_tval  <= 32'd0;
                        state     <= FLUSH;
                        flush_req <= 1'b1;
                    end
                end

                FLUSH: begin
                    if (flush_ack) begin
                        state         <= COMMIT;
                        flush_req     <= 1'b0;
                        o_mstatus_mpp <= MPP_VALUE;
                        if (lat_mret) begin
                            mret_take      <= 1'b1;
                            o_mstatus_mie  <= i_mstatus_mpie;
                            o_mstatus_mpie <= 1'b1;
                        end else begin
                            trap_take               <= 1'b1;
                            o_mcause_interrupt      <= lat_int;
                            o_mcause_exception_code <= {27'd0, lat_code};
                            o_mepc_value            <= lat_epc;
                            o_mtval_value           <= lat_tval;
                            o_mstatus_mie           <= 1'b0;
                            o_mstatus_mpie          <= i_mstatus_mie;
                        end
                    end
                end

                COMMIT: begin
                    state          <= REDIRECT;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= target;
                end

                REDIRECT: begin
                    state <= IDLE;
                end

                default: begin
                    state     <= IDLE;
                    flush_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized
// transactions checked against a transaction-level trap model.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_valid;
    logic [3:0]  exc_code;
    logic [31:0] exc_pc;
    logic [31:0] exc_tval;
    logic        mret_valid;
    logic        boundary_valid;
    logic [31:0] boundary_pc;
    logic        irq_sw, irq_timer, irq_ext;
    logic        i_mstatus_mie, i_mstatus_mpie;
    logic        i_mie_msie, i_mie_mtie, i_mie_meie;
    logic [29:0] i_mtvec_base;
    logic [1:0]  i_mtvec_mode;
    logic [31:0] i_mepc_value;
    logic        flush_req;
    logic        flush_ack;
    logic        trap_take;
    logic        mret_take;
    logic        o_mcause_interrupt;
    logic [30:0] o_mcause_exception_code;
    logic [31:0] o_mepc_value;
    logic [31:0] o_mtval_value;
    logic        o_mstatus_mie, o_mstatus_mpie;
    logic [1:0]  o_mstatus_mpp;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    always #5 clk = ~clk;

    trap_ctrl #(.VECTORED_EN(1'b1), .MPP_VALUE(2'b11)) dut (
        .clk(clk), .rst(rst),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .mret_valid(mret_valid), .boundary_valid(boundary_valid), .boundary_pc(boundary_pc),
        .irq_sw(irq_sw), .irq_timer(irq_timer), .irq_ext(irq_ext),
        .i_mstatus_mie(i_mstatus_mie), .i_mstatus_mpie(i_mstatus_mpie),
        .i_mie_msie(i_mie_msie), .i_mie_mtie(i_mie_mtie), .i_mie_meie(i_mie_meie),
        .i_mtvec_base(i_mtvec_base), .i_mtvec_mode(i_mtvec_mode), .i_mepc_value(i_mepc_value),
        .flush_req(flush_req), .flush_ack(flush_ack),
        .trap_take(trap_take), .mret_take(mret_take),
        .o_mcause_interrupt(o_mcause_interrupt), .o_mcause_exception_code(o_mcause_exception_code),
        .o_mepc_value(o_mepc_value), .o_mtval_value(o_mtval_value),
        .o_mstatus_mie(o_mstatus_mie), .o_mstatus_mpie(o_mstatus_mpie), .o_mstatus_mpp(o_mstatus_mpp),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Expected transaction produced by the model.
    bit          e_valid, e_mret, e_int;
    logic [3:0]  e_code;
    logic [31:0] e_epc, e_tval, e_tgt;
    logic        e_mie, e_mpie;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Architectural view: mip/mie as 16-bit vectors indexed by cause code.
    task automatic predict();
        logic [15:0] mip_v, mie_v;
        int prio[3];
        prio = '{11, 3, 7};
        mip_v = '0;
        mie_v = '0;
        mip_v[3] = irq_sw;  mip_v[7] = irq_timer;  mip_v[11] = irq_ext;
        mie_v[3] = i_mie_msie; mie_v[7] = i_mie_mtie; mie_v[11] = i_mie_meie;
        e_valid = 1'b0; e_mret = 1'b0; e_int = 1'b0;
        e_code = 4'd0; e_epc = 32'd0; e_tval = 32'd0;
        if (exc_valid) begin
            e_valid = 1'b1; e_code = exc_code; e_epc = exc_pc; e_tval = exc_tval;
        end else if (mret_valid) begin
            e_valid = 1'b1; e_mret = 1'b1;
        end else if (boundary_valid && i_mstatus_mie) begin
            for (int i = 0; i < 3; i++) begin
                if (!e_valid && mip_v[prio[i]] && mie_v[prio[i]]) begin
                    e_valid = 1'b1; e_int = 1'b1;
                    e_code = 4'(prio[i]); e_epc = boundary_pc;
                end
            end
        end
        if (e_mret) begin
            e_tgt  = i_mepc_value - (i_mepc_value % 4);
            e_mie  = i_mstatus_mpie;
            e_mpie = 1'b1;
        end else begin
            e_tgt = 32'(i_mtvec_base) * 4;
            if (i_mtvec_mode == 2'b01 && e_int) e_tgt = e_tgt + 32'(e_code) * 4;
            e_mie  = 1'b0;
            e_mpie = i_mstatus_mie;
        end
    endtask

    task automatic clear_inputs();
        exc_valid = 0; exc_code = 0; exc_pc = 0; exc_tval = 0;
        mret_valid = 0; boundary_valid = 0; boundary_pc = 0;
        irq_sw = 0; irq_timer = 0; irq_ext = 0;
        i_mstatus_mie = 0; i_mstatus_mpie = 0;
        i_mie_msie = 0; i_mie_mtie = 0; i_mie_meie = 0;
        i_mtvec_base = 0; i_mtvec_mode = 0; i_mepc_value = 0;
        flush_ack = 0;
    endtask

    // Called just after a rising edge with request inputs already driven.
    // d = number of extra FLUSH cycles before the ack arrives.
    task automatic run_txn(input string name, input int d, input bit inject);
        int  k;
        bit  seen;
        predict();
        flush_ack = (d == 0);
        @(posedge clk); #1;
        exc_valid = 0; mret_valid = 0; boundary_valid = 0;
        if (!e_valid) begin
            repeat (3) begin
                @(negedge clk);
                chk({name, "_idle_busy"}, 32'(busy), 32'd0);
                chk({name, "_idle_flush"}, 32'(flush_req), 32'd0);
                chk({name, "_idle_take"}, 32'(trap_take | mret_take), 32'd0);
            end
            return;
        end
        k = 0;
        seen = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (trap_take || mret_take) begin
                seen = 1;
            end else begin
                chk({name, "_flush_req"}, 32'(flush_req), 32'd1);
                chk({name, "_busy"}, 32'(busy), 32'd1);
                if (inject && k <= d) begin
                    exc_valid = 1'b1;
                    exc_code  = 4'($urandom_range(0, 15));
                    exc_pc    = $urandom;
                end else begin
                    exc_valid = 1'b0;
                end
                if (k == d + 1) flush_ack = 1'b1;
            end
        end
        exc_valid = 0;
        if (!seen) begin
            chk({name, "_commit_timeout"}, 32'd0, 32'd1);
            return;
        end
        flush_ack = 0;
        chk({name, "_commit_lat"}, 32'(k), 32'(d + 2));
        chk({name, "_trap_take"}, 32'(trap_take), 32'(!e_mret));
        chk({name, "_mret_take"}, 32'(mret_take), 32'(e_mret));
        chk({name, "_flush_drop"}, 32'(flush_req), 32'd0);
        chk({name, "_mcause_int"}, 32'(o_mcause_interrupt), 32'(e_int));
        chk({name, "_mcause_code"}, 32'(o_mcause_exception_code), 32'(e_code));
        chk({name, "_mepc"}, o_mepc_value, e_epc);
        chk({name, "_mtval"}, o_mtval_value, e_tval);
        chk({name, "_mie"}, 32'(o_mstatus_mie), 32'(e_mie));
        chk({name, "_mpie"}, 32'(o_mstatus_mpie), 32'(e_mpie));
        chk({name, "_mpp"}, 32'(o_mstatus_mpp), 32'd3);
        @(negedge clk);
        chk({name, "_redir_valid"}, 32'(redirect_valid), 32'd1);
        chk({name, "_redir_pc"}, redirect_pc, e_tgt);
        chk({name, "_take_low"}, 32'(trap_take | mret_take), 32'd0);
        chk({name, "_csr_zero"}, o_mepc_value | o_mtval_value, 32'd0);
        @(negedge clk);
        chk({name, "_done_busy"}, 32'(busy), 32'd0);
        chk({name, "_done_redir"}, 32'(redirect_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flush", 32'(flush_req), 32'd0);
        chk("rst_redir", redirect_pc, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Direct-mode exception.
        i_mstatus_mie = 1; i_mtvec_base = 30'h80; i_mtvec_mode = 2'b00;
        exc_valid = 1; exc_code = 4'd2; exc_pc = 32'h100; exc_tval = 32'hDEAD;
        run_txn("exc", 0, 0);

        // Interrupt priority, vectored.
        i_mtvec_base = 30'h400; i_mtvec_mode = 2'b01;
        irq_ext = 1; irq_timer = 1; irq_sw = 1;
        i_mie_meie = 1; i_mie_mtie = 1; i_mie_msie = 1;
        boundary_valid = 1; boundary_pc = 32'h80;
        run_txn("irq_mei", 0, 0);
        irq_ext = 0; boundary_valid = 1;
        run_txn("irq_msi", 0, 0);

        // Masked interrupt, then exception over MRET.
        i_mstatus_mie = 0; irq_sw = 0; irq_timer = 1; boundary_valid = 1;
        run_txn("masked", 0, 0);
        irq_timer = 0; i_mstatus_mie = 1;
        exc_valid = 1; mret_valid = 1; exc_code = 4'd5; exc_pc = 32'h44; exc_tval = 32'h9;
        run_txn("exc_over_mret", 1, 0);

        // MRET.
        i_mepc_value = 32'h3A2; i_mstatus_mpie = 1; i_mstatus_mie = 0;
        mret_valid = 1;
        run_txn("mret", 0, 0);

        // Flush stall with a stray exception during the stall.
        i_mstatus_mie = 1; i_mtvec_base = 30'h123; i_mtvec_mode = 2'b11;
        exc_valid = 1; exc_code = 4'd13; exc_pc = 32'h2000; exc_tval = 32'h77;
        run_txn("stall", 5, 1);

        // Reset during FLUSH.
        exc_valid = 1; exc_code = 4'd1; flush_ack = 0;
        @(posedge clk); #1;
        exc_valid = 0;
        @(negedge clk);
        chk("rstmid_flush_before", 32'(flush_req), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("rstmid_flush", 32'(flush_req), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_take", 32'(trap_take | redirect_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1; flush_ack = 1;
        repeat (5) begin
            @(negedge clk);
            chk("rstmid_no_take", 32'(trap_take | mret_take | redirect_valid), 32'd0);
            chk("rstmid_idle", 32'(busy), 32'd0);
        end
        flush_ack = 0;
        @(posedge clk); #1;

        // Randomized transactions.
        for (int t = 0; t < 60; t++) begin
            exc_valid      = ($urandom_range(0, 3) == 0);
            exc_code       = 4'($urandom_range(0, 15));
            exc_pc         = $urandom;
            exc_tval       = $urandom;
            mret_valid     = ($urandom_range(0, 3) == 0);
            boundary_valid = $urandom_range(0, 1);
            boundary_pc    = $urandom;
            irq_sw         = $urandom_range(0, 1);
            irq_timer      = $urandom_range(0, 1);
            irq_ext        = $urandom_range(0, 1);
            i_mstatus_mie  = $urandom_range(0, 1);
            i_mstatus_mpie = $urandom_range(0, 1);
            i_mie_msie     = $urandom_range(0, 1);
            i_mie_mtie     = $urandom_range(0, 1);
            i_mie_meie     = $urandom_range(0, 1);
            i_mtvec_base   = 30'($urandom);
            i_mtvec_mode   = 2'($urandom_range(0, 3));
            i_mepc_value   = $urandom;
            run_txn("rand", int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
